// File: rtl/wrapper_stream.sv
// wrapper_stream: sits between a test driver and the DUT `top` instance.
// Input words arrive one at a time on a valid/ready load channel and are
// collected in a shadow register. The whole vector is then committed to the
// DUT in a single cycle. After a configurable settle time the DUT output is
// captured, and the captured words are streamed back one at a time.
//
// Handshake rule for both channels: a word transfers on a rising clkin edge
// where valid && ready. The ready and valid outputs come from registered
// state only, so they never depend combinationally on the partner's signals.
// A producer may hold valid high for as long as it likes; nothing transfers
// while the matching ready is low.
module wrapper_stream #(
  parameter int W         = 32,
  parameter int IN_WORDS  = 3,
  parameter int OUT_WORDS = 3,
  parameter int SETTLE    = 2
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_last,
  output logic [IN_WORDS*W-1:0]  dut_in,
  input  logic [OUT_WORDS*W-1:0] dut_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [31:0]            commit_cnt,
  output logic [1:0]             state_dbg
);

  localparam int IW = (IN_WORDS  > 1) ? $clog2(IN_WORDS)  : 1;
  localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int SW = (SETTLE    > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IW-1:0] IDX_MAX  = IW'(IN_WORDS - 1);
  localparam logic [OW-1:0] ODX_MAX  = OW'(OUT_WORDS - 1);
  localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_APPLY = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx;
  logic [OW-1:0]          oidx;
  logic [SW-1:0]          settle_cnt;
  logic [IN_WORDS*W-1:0]  shadow;
  logic [OUT_WORDS*W-1:0] snapshot;
  logic                   load_fire;
  logic                   load_commit;
  logic                   drain_fire;
  logic                   drain_done;

  // Handshake qualifiers, all derived from the registered state
  always_comb begin
    load_fire   = 1'b0;
    load_commit = 1'b0;
    drain_fire  = 1'b0;
    drain_done  = 1'b0;
    if (state_q == ST_LOAD && in_valid) begin
      load_fire   = 1'b1;
      load_commit = in_last || (idx == IDX_MAX);
    end
    if (state_q == ST_DRAIN && out_ready) begin
      drain_fire = 1'b1;
      drain_done = (oidx == ODX_MAX);
    end
  end

  // State register
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (load_commit) state_d = ST_APPLY;
      ST_APPLY: state_d = ST_WAIT;
      ST_WAIT:  if (settle_cnt == '0) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase
  end

  // Datapath: shadow fill, atomic commit, settle countdown, capture, drain index
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      oidx       <= '0;
      settle_cnt <= '0;
      shadow     <= '0;
      dut_in     <= '0;
      snapshot   <= '0;
      commit_cnt <= '0;
    end else begin
      if (load_fire) begin
        shadow[idx*W +: W] <= in_data;
        idx <= load_commit ? '0 : idx + 1'b1;
      end
      if (state_q == ST_APPLY) begin
        dut_in     <= shadow;
        commit_cnt <= commit_cnt + 32'd1;
        settle_cnt <= SETTLE_V;
      end
      // Capture at the end of the cycle SETTLE cycles after dut_in changed
      if (state_q == ST_WAIT) begin
        if (settle_cnt == '0) snapshot <= dut_out;
        else                  settle_cnt <= settle_cnt - 1'b1;
      end
      if (drain_fire) begin
        oidx <= drain_done ? '0 : oidx + 1'b1;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    busy      = (state_q != ST_LOAD);
    out_valid = (state_q == ST_DRAIN);
    out_last  = 1'b0;
    out_data  = '0;
    state_dbg = state_q;
    if (state_q == ST_DRAIN) begin
      out_data = snapshot[oidx*W +: W];
      out_last = (oidx == ODX_MAX);
    end
  end

endmodule
